img_port_arbiter: RTL and testbench
===================================

IMG_PORT_ARBITER -- requirements
Module: img_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning image memory address width.
REQ-002 SHALL have parameter DATA_W, default 8, meaning pixel data width.
REQ-003 SHALL have parameter MAX_BURST, default 16, meaning max consecutive accepted beats per grant while the other requester waits (>=2).
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous, active-low.
REQ-006 SHALL have port r0_req, input, 1, requester 0 (CCL labelling pass) read request.
REQ-007 SHALL have port r0_addr, input, ADDR_W, requester 0 pixel address.
REQ-008 SHALL have port r0_gnt, output, 1, requester 0 beat accepted this cycle.
REQ-009 SHALL have port r0_rvalid, output, 1, requester 0 read data valid.
REQ-010 SHALL have port r0_rdata, output, DATA_W, requester 0 read data.
REQ-011 SHALL have ports r1_req, r1_addr, r1_gnt, r1_rvalid, r1_rdata, same directions/widths/meanings, for requester 1 (object/character recognition pass).
REQ-012 SHALL have port mem_en, output, 1, image memory read enable.
REQ-013 SHALL have port mem_addr, output, ADDR_W, image memory address.
REQ-014 SHALL have port mem_rdata, input, DATA_W, image memory data, valid one cycle after mem_en.
REQ-015 SHALL have port owner, output, 2, current owner: 00 none, 01 r0, 10 r1.
REQ-016 SHALL have port busy, output, 1, high when owner != 00.

Function
REQ-017 SHALL implement FSM states IDLE, GRANT0, GRANT1; owner/busy decode directly from state.
REQ-018 IDLE: only r0_req -> GRANT0; only r1_req -> GRANT1; both -> grant requester not equal to last_owner; neither -> stay.
REQ-019 GRANTx: r_x_req low -> GRANT(other) if other req high, else IDLE.
REQ-020 GRANTx: accepted beat with beat_cnt == MAX_BURST-1 and other req high -> GRANT(other).
REQ-021 GRANTx otherwise SHALL stay; beat_cnt at MAX_BURST-1 with other idle wraps to 0, grant held.
REQ-022 beat_cnt SHALL clear on every state change and increment on each accepted beat.
REQ-023 last_owner SHALL update to x on entry to GRANTx.
REQ-024 r_x_gnt SHALL equal (state==GRANTx) && r_x_req, combinational; never both gnt high.
REQ-025 mem_en SHALL equal r0_gnt | r1_gnt; mem_addr SHALL be owner's addr when granted, else 0.
REQ-026 Request to first grant latency SHALL be 1 cycle from IDLE (req at cycle N, gnt at N+1).
REQ-027 r_x_rvalid SHALL pulse exactly one cycle after each r_x_gnt, with r_x_rdata = mem_rdata that cycle; rdata holds last value otherwise.
REQ-028 In-flight beat SHALL be delivered to its issuer even if ownership changes on the same edge.
REQ-029 Requesters SHALL hold addr stable while req high and gnt low; arbiter does not buffer addresses.
REQ-030 Simultaneous owner drop and other request SHALL switch without an IDLE cycle.

Reset
REQ-031 rst low at a clock edge SHALL set state IDLE, last_owner = r1 (r0 wins first tie), beat_cnt 0.
REQ-032 During/after reset: all gnt, rvalid, mem_en 0; rdata 0; mem_addr 0; owner 00; busy 0.
REQ-033 Reset mid-burst SHALL drop any pending rvalid; no beat delivered the cycle after reset deasserts.

Verification
REQ-034 Reset then r0_req=1, r0_addr=0x0010 at cycle 1 -> r0_gnt, mem_en at cycle 2, mem_addr 0x0010; r0_rvalid cycle 3 with mem_rdata value.
REQ-035 Both req high from IDLE after reset -> GRANT0 first; r0 gets 16 beats, then owner 10 with no gap cycle; r1 gets 16; alternates.
REQ-036 r1 alone, 40 beats -> grant held continuously, 40 rvalid pulses, beat_cnt wraps twice, owner stays 10.
REQ-037 r0 drops req same cycle r1 raises it -> next cycle owner 10, r1_gnt high, r0's last rvalid still delivered to r0 only.
REQ-038 rst low during GRANT1 beat 5 -> next cycle all outputs 0, no r1_rvalid; after release, both req -> r0 granted.
REQ-039 Randomised two-requester run, scoreboard -> every gnt matched by one rvalid to same requester, data equals model memory[addr], never both gnt high.

Source files
------------

// File: rtl/img_port_arbiter.sv
// Two-requester read arbiter for the shared image memory.
// Bounded bursts, alternating tie-break, one-cycle read return.
module img_port_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic [ADDR_W-1:0] r0_addr,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic [ADDR_W-1:0] r1_addr,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        owner,
  output logic              busy
);

  localparam int CW = $clog2(MAX_BURST);
  localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_last;
  logic [CW-1:0]   r_cnt;
  logic            r_rv0;
  logic            r_rv1;
  logic [DATA_W-1:0] r_rd0;
  logic [DATA_W-1:0] r_rd1;
  logic            w_gnt0;
  logic            w_gnt1;
  logic            w_rv0;
  logic            w_rv1;
  logic            w_wrap;

  // Outputs are gated by rst so nothing leaks while reset is held.
  assign w_gnt0 = rst && (r_state == GRANT0) && r0_req;
  assign w_gnt1 = rst && (r_state == GRANT1) && r1_req;
  assign w_rv0  = rst && r_rv0;
  assign w_rv1  = rst && r_rv1;
  assign w_wrap = (r_cnt == LAST);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (r0_req && r1_req)
          w_next = r_last ? GRANT0 : GRANT1;
        else if (r0_req)
          w_next = GRANT0;
        else if (r1_req)
          w_next = GRANT1;
      end
      GRANT0: begin
        if (!r0_req)
          w_next = r1_req ? GRANT1 : IDLE;
        else if (w_wrap && r1_req)
          w_next = GRANT1;
      end
      GRANT1: begin
        if (!r1_req)
          w_next = r0_req ? GRANT0 : IDLE;
        else if (w_wrap && r0_req)
          w_next = GRANT0;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_cnt   <= '0;
      r_rv0   <= 1'b0;
      r_rv1   <= 1'b0;
      r_rd0   <= '0;
      r_rd1   <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_cnt <= '0;
      else if (w_gnt0 || w_gnt1)
        r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      if (w_next == GRANT0 && r_state != GRANT0)
        r_last <= 1'b0;
      else if (w_next == GRANT1 && r_state != GRANT1)
        r_last <= 1'b1;
      r_rv0 <= w_gnt0;
      r_rv1 <= w_gnt1;
      if (r_rv0)
        r_rd0 <= mem_rdata;
      if (r_rv1)
        r_rd1 <= mem_rdata;
    end
  end

  assign r0_gnt    = w_gnt0;
  assign r1_gnt    = w_gnt1;
  assign r0_rvalid = w_rv0;
  assign r1_rvalid = w_rv1;
  // Data is steered straight from memory on the return cycle, held after.
  assign r0_rdata  = !rst ? '0 : (w_rv0 ? mem_rdata : r_rd0);
  assign r1_rdata  = !rst ? '0 : (w_rv1 ? mem_rdata : r_rd1);
  assign mem_en    = w_gnt0 || w_gnt1;
  assign mem_addr  = w_gnt0 ? r0_addr : (w_gnt1 ? r1_addr : '0);
  assign owner     = rst ? r_state : 2'b00;
  assign busy      = rst && (r_state != IDLE);

endmodule

// File: tb/tb_img_port_arbiter.sv
// Directed and scoreboarded bench for img_port_arbiter.
// Memory model returns f(addr) one cycle after mem_en.
module tb_img_port_arbiter;

  logic        clk;
  logic        rst;
  logic        r0_req;
  logic [15:0] r0_addr;
  logic        r0_gnt;
  logic        r0_rvalid;
  logic [7:0]  r0_rdata;
  logic        r1_req;
  logic [15:0] r1_addr;
  logic        r1_gnt;
  logic        r1_rvalid;
  logic [7:0]  r1_rdata;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic [1:0]  owner;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  img_port_arbiter dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_addr(r0_addr), .r0_gnt(r0_gnt),
    .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_addr(r1_addr), .r1_gnt(r1_gnt),
    .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .owner(owner), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] f(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  initial mem_rdata = 8'h00;
  always @(posedge clk)
    if (mem_en) mem_rdata <= f(mem_addr);

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    nxt();
    rst = 1'b0;
    r0_req = 1'b0;
    r1_req = 1'b0;
    nxt();
    nxt();
    rst = 1'b1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ctl"},
          {r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_en, busy}, 0);
    check({tag, "_own"}, owner, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_rd"}, {r0_rdata, r1_rdata}, 0);
  endtask

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic        g0s;
  logic        g1s;

  task automatic sb_cycle();
    logic [15:0] e;
    check("rnd_excl", r0_gnt & r1_gnt, 0);
    if (r0_rvalid) begin
      check("rnd_rv0_pend", q0.size() != 0, 1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        check("rnd_rd0", r0_rdata, f(e));
      end
    end
    if (r1_rvalid) begin
      check("rnd_rv1_pend", q1.size() != 0, 1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        check("rnd_rd1", r1_rdata, f(e));
      end
    end
    if (r0_gnt) begin
      q0.push_back(r0_addr);
      check("rnd_maddr0", mem_addr, r0_addr);
    end
    if (r1_gnt) begin
      q1.push_back(r1_addr);
      check("rnd_maddr1", mem_addr, r1_addr);
    end
    g0s = r0_gnt;
    g1s = r1_gnt;
  endtask

  initial begin
    int rvc;
    logic e0;
    logic p0;
    logic p1;
    rst = 1'b0;
    r0_req = 1'b0;
    r1_req = 1'b0;
    r0_addr = '0;
    r1_addr = '0;

    // reset state
    nxt();
    nxt();
    smp();
    check_quiet("rst");

    // single beat from IDLE
    nxt();
    rst = 1'b1;
    r0_req = 1'b1;
    r0_addr = 16'h0010;
    smp();
    check("t1_c1_gnt", {r0_gnt, r1_gnt, mem_en}, 0);
    check("t1_c1_own", owner, 0);
    nxt();
    smp();
    check("t1_c2_gnt", {r0_gnt, r1_gnt, mem_en}, 3'b101);
    check("t1_c2_addr", mem_addr, 16'h0010);
    check("t1_c2_own", {owner, busy}, 3'b011);
    nxt();
    r0_req = 1'b0;
    smp();
    check("t1_c3_rv", {r0_rvalid, r1_rvalid, r0_gnt}, 3'b100);
    check("t1_c3_rd", r0_rdata, f(16'h0010));
    nxt();
    smp();
    check("t1_c4_rv", r0_rvalid, 0);
    check("t1_c4_hold", r0_rdata, f(16'h0010));
    check("t1_c4_own", {owner, busy}, 0);

    // both request: 16-beat bursts, alternating, no gap
    do_reset();
    r0_req = 1'b1;
    r1_req = 1'b1;
    r0_addr = 16'h0020;
    r1_addr = 16'h0030;
    smp();
    check("t2_c0_own", owner, 0);
    p0 = 1'b0;
    p1 = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      nxt();
      smp();
      e0 = (((k - 1) / 16) % 2) == 0;
      check($sformatf("t2_k%0d_hs", k),
            {r0_gnt, r1_gnt, r0_rvalid, r1_rvalid}, {e0, !e0, p0, p1});
      check($sformatf("t2_k%0d_own", k), owner, {!e0, e0});
      check($sformatf("t2_k%0d_addr", k), mem_addr,
            e0 ? 16'h0020 : 16'h0030);
      if (p0) check("t2_rd0", r0_rdata, f(16'h0020));
      if (p1) check("t2_rd1", r1_rdata, f(16'h0030));
      p0 = e0;
      p1 = !e0;
    end
    nxt();
    r0_req = 1'b0;
    r1_req = 1'b0;

    // r1 alone for 40 beats, counter wraps, grant held
    do_reset();
    r1_req = 1'b1;
    r1_addr = 16'h0300;
    rvc = 0;
    for (int k = 1; k <= 40; k++) begin
      nxt();
      r1_addr = 16'h0300 + 16'(k);
      smp();
      check($sformatf("t3_k%0d_g", k), {r0_gnt, r1_gnt, owner}, 4'b0110);
      if (r1_rvalid) begin
        rvc++;
        check("t3_rd", r1_rdata, f(16'h0300 + 16'(k - 1)));
      end
    end
    nxt();
    r1_req = 1'b0;
    smp();
    check("t3_last_g", r1_gnt, 0);
    check("t3_last_rv", r1_rvalid, 1);
    if (r1_rvalid) begin
      rvc++;
      check("t3_last_rd", r1_rdata, f(16'h0328));
    end
    nxt();
    smp();
    check("t3_end_rv", r1_rvalid, 0);
    check("t3_rv_count", rvc, 40);

    // r0 drops while r1 raises: hand over, r0 keeps its beat
    do_reset();
    r0_req = 1'b1;
    r0_addr = 16'h0040;
    for (int k = 1; k <= 3; k++) begin
      nxt();
      smp();
      check($sformatf("t4_k%0d_g0", k), r0_gnt, 1);
    end
    nxt();
    r0_req = 1'b0;
    r1_req = 1'b1;
    r1_addr = 16'h0050;
    smp();
    check("t4_drop_hs", {r0_gnt, r1_gnt, r0_rvalid, r1_rvalid}, 4'b0010);
    check("t4_drop_rd", r0_rdata, f(16'h0040));
    nxt();
    smp();
    check("t4_sw_own", owner, 2'b10);
    check("t4_sw_hs", {r0_gnt, r1_gnt, r0_rvalid, r1_rvalid}, 4'b0100);
    check("t4_sw_addr", mem_addr, 16'h0050);
    nxt();
    r1_req = 1'b0;
    smp();
    check("t4_rv1", {r0_rvalid, r1_rvalid}, 2'b01);
    check("t4_rd1", r1_rdata, f(16'h0050));

    // reset during GRANT1 beat 5
    do_reset();
    r1_req = 1'b1;
    r1_addr = 16'h0060;
    for (int k = 1; k <= 4; k++) nxt();
    nxt();
    rst = 1'b0;
    smp();
    check_quiet("t5_c5");
    nxt();
    smp();
    check_quiet("t5_c6");
    nxt();
    rst = 1'b1;
    r0_req = 1'b1;
    r0_addr = 16'h0070;
    smp();
    check("t5_rel_hs", {r0_gnt, r1_gnt, r0_rvalid, r1_rvalid}, 0);
    check("t5_rel_own", owner, 0);
    nxt();
    smp();
    check("t5_tie_own", owner, 2'b01);
    check("t5_tie_hs", {r0_gnt, r1_gnt, r1_rvalid}, 3'b100);
    nxt();
    r0_req = 1'b0;
    r1_req = 1'b0;

    // randomised two-requester run with scoreboard
    do_reset();
    q0.delete();
    q1.delete();
    g0s = 1'b0;
    g1s = 1'b0;
    smp();
    for (int i = 0; i < 400; i++) begin
      nxt();
      if (!(r0_req && !g0s)) begin
        r0_req = ($urandom_range(0, 3) != 0);
        r0_addr = 16'($urandom);
      end
      if (!(r1_req && !g1s)) begin
        r1_req = ($urandom_range(0, 3) != 0);
        r1_addr = 16'($urandom);
      end
      smp();
      sb_cycle();
    end
    for (int i = 0; i < 3; i++) begin
      nxt();
      r0_req = 1'b0;
      r1_req = 1'b0;
      smp();
      sb_cycle();
    end
    check("rnd_q0_empty", q0.size(), 0);
    check("rnd_q1_empty", q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
